// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential signed multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int ERR_OVF  = 1;
   localparam int ERR_RSVD = 0;

   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_multiply_if.sv
// rtl/seq_multiply_if.sv - operand/result handshake bundle for seq_multiply.
interface seq_multiply_if #(
   parameter int WIDTH     = 16,
   parameter int OUT_WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] product;
   logic [1:0]           error;

   modport master (
      output in_valid, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product, error
   );

   modport slave (
      input  in_valid, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product, error
   );
endinterface

// File: rtl/seq_multiply_signed_abs.sv
// rtl/seq_multiply_signed_abs.sv - two's-complement to sign + unsigned magnitude.
module signed_abs #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] mag,
   output logic             neg
);
   // The most negative value maps onto itself, which read unsigned is exactly 2^(WIDTH-1).
   assign neg = value[WIDTH-1];
   assign mag = neg ? (~value + 1'b1) : value;
endmodule

// File: rtl/seq_multiply.sv
// rtl/seq_multiply.sv - radix-2 shift-add signed multiplier, one multiplier bit per clock.
module seq_multiply
   import mult_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int OUT_WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_multiply_if.slave bus
);
   localparam int CW = cnt_width(WIDTH);
   localparam int AW = 2 * WIDTH;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic [WIDTH-1:0]     mag_a_q, mag_a_d;
   logic [WIDTH-1:0]     mag_b_q, mag_b_d;
   logic                 sign_q, sign_d;
   logic [OUT_WIDTH-1:0] product_q, product_d;
   logic                 ovf_q, ovf_d;

   logic [WIDTH-1:0]     mag_a, mag_b;
   logic                 neg_a, neg_b;
   logic [AW-1:0]        full;
   logic [OUT_WIDTH-1:0] prod_fix;
   logic                 ovf_fix;

   signed_abs #(.WIDTH(WIDTH)) u_abs_a (.value(bus.multiplicand), .mag(mag_a), .neg(neg_a));
   signed_abs #(.WIDTH(WIDTH)) u_abs_b (.value(bus.multiplier),   .mag(mag_b), .neg(neg_b));

   assign full = sign_q ? (~acc_q + 1'b1) : acc_q;

   generate
      if (OUT_WIDTH >= AW) begin : g_wide
         assign prod_fix = OUT_WIDTH'($signed(full));
         assign ovf_fix  = 1'b0;
      end else begin : g_narrow
         // Representable only if every bit from the kept sign bit upward matches.
         logic [AW-OUT_WIDTH:0] top_bits;
         assign top_bits = full[AW-1:OUT_WIDTH-1];
         assign prod_fix = full[OUT_WIDTH-1:0];
         assign ovf_fix  = !((&top_bits) || !(|top_bits));
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mag_a_d   = mag_a_q;
      mag_b_d   = mag_b_q;
      sign_d    = sign_q;
      product_d = product_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mag_a_d = mag_a;
               mag_b_d = mag_b;
               sign_d  = neg_a ^ neg_b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (mag_b_q[cnt_q]) begin
               acc_d = acc_q + (AW'(mag_a_q) << cnt_q);
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            product_d = prod_fix;
            ovf_d     = ovf_fix;
            state_d   = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         sign_q    <= 1'b0;
         product_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mag_a_q   <= mag_a_d;
         mag_b_q   <= mag_b_d;
         sign_q    <= sign_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      bus.error           = '0;
      bus.error[ERR_OVF]  = ovf_q;
      bus.error[ERR_RSVD] = 1'b0;
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.product   = product_q;
endmodule

// File: tb/tb_seq_multiply.sv
// tb/tb_seq_multiply.sv - directed checks of seq_multiply at 32-bit and 16-bit product widths.
module tb_seq_multiply;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] multiplicand;
   logic [15:0] multiplier;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   seq_multiply_if #(.WIDTH(16), .OUT_WIDTH(32)) bus32 ();
   seq_multiply_if #(.WIDTH(16), .OUT_WIDTH(16)) bus16 ();

   assign bus32.in_valid     = in_valid;
   assign bus32.out_ready    = out_ready;
   assign bus32.multiplicand = multiplicand;
   assign bus32.multiplier   = multiplier;
   assign bus16.in_valid     = in_valid;
   assign bus16.out_ready    = out_ready;
   assign bus16.multiplicand = multiplicand;
   assign bus16.multiplier   = multiplier;

   seq_multiply #(.WIDTH(16), .OUT_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   seq_multiply #(.WIDTH(16), .OUT_WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Counts edges from the accept edge (inclusive) to the edge that raises out_valid.
   task automatic wait_done(output int lat, output logic busy_ok);
      lat     = 1;
      busy_ok = 1'b1;
      while (!bus32.out_valid && lat < 40) begin
         if (bus32.in_ready || bus16.in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] p32, input logic e32,
                         input logic [15:0] p16, input logic e16);
      int   lat;
      logic busy_ok;
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      in_valid     = 1'b1;
      out_ready    = 1'b1;
      check({tag, " in_ready"}, 32'(bus32.in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid     = 1'b0;
      multiplicand = 16'h5555;
      multiplier   = 16'haaaa;
      wait_done(lat, busy_ok);
      check({tag, " latency"}, 32'(lat), 32'd18);
      check({tag, " busy"}, 32'(busy_ok), 32'd1);
      check({tag, " p32"}, bus32.product, p32);
      check({tag, " e32"}, 32'(bus32.error), 32'({e32, 1'b0}));
      check({tag, " p16"}, 32'(bus16.product), 32'(p16));
      check({tag, " e16"}, 32'(bus16.error), 32'({e16, 1'b0}));
      @(posedge clk); #1;
      check({tag, " drop"}, 32'({bus32.out_valid, bus32.in_ready}), 32'b01);
      check({tag, " keep"}, bus32.product, p32);
   endtask

   initial begin
      int   lat;
      logic busy_ok;
      logic stable_ok;
      logic quiet_ok;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b1;
      multiplicand = '0;
      multiplier   = '0;
      #1;
      check("rst ready_valid", 32'({bus32.in_ready, bus32.out_valid}), 32'b10);
      check("rst product", bus32.product, 32'd0);
      check("rst error", 32'(bus32.error), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("16x1",      16'd16,     16'd1,     32'h0000_0010, 1'b0, 16'h0010, 1'b0);
      run_op("m3x53",     -16'sd3,    16'd53,    32'hFFFF_FF61, 1'b0, 16'hFF61, 1'b0);
      run_op("m55xm159",  -16'sd55,   -16'sd159, 32'h0000_2229, 1'b0, 16'h2229, 1'b0);
      run_op("minxmin",   16'h8000,   16'h8000,  32'h4000_0000, 1'b0, 16'h0000, 1'b1);
      run_op("0x1234",    16'd0,      16'd1234,  32'h0000_0000, 1'b0, 16'h0000, 1'b0);
      run_op("300x300",   16'd300,    16'd300,   32'h0001_5F90, 1'b0, 16'h5F90, 1'b1);
      run_op("m128x256",  -16'sd128,  16'd256,   32'hFFFF_8000, 1'b0, 16'h8000, 1'b0);

      // Result held with out_ready low while new operands wait.
      @(negedge clk);
      multiplicand = 16'd1000;
      multiplier   = -16'sd2;
      in_valid     = 1'b1;
      out_ready    = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(lat, busy_ok);
      check("hold latency", 32'(lat), 32'd18);
      multiplicand = 16'd7;
      multiplier   = -16'sd9;
      in_valid     = 1'b1;
      stable_ok    = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus32.product !== 32'hFFFF_F830 || bus32.error !== 2'b00 ||
             bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0 ||
             bus16.product !== 16'hF830) stable_ok = 1'b0;
      end
      check("hold stable", 32'(stable_ok), 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold release", 32'({bus32.out_valid, bus32.in_ready}), 32'b01);
      @(posedge clk); #1;
      check("hold accept", 32'(bus32.in_ready), 32'd0);
      in_valid = 1'b0;
      wait_done(lat, busy_ok);
      check("held op latency", 32'(lat), 32'd18);
      check("held op p32", bus32.product, 32'hFFFF_FFC1);
      check("held op p16", 32'(bus16.product), 32'h0000_FFC1);
      @(posedge clk); #1;

      // Asynchronous reset in the seventh CALC cycle.
      @(negedge clk);
      multiplicand = 16'd5;
      multiplier   = 16'd6;
      in_valid     = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst ready_valid", 32'({bus32.in_ready, bus32.out_valid}), 32'b10);
      check("arst product", bus32.product, 32'd0);
      check("arst error", 32'(bus16.error), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      quiet_ok = 1'b1;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus32.out_valid || bus16.out_valid || !bus32.in_ready) quiet_ok = 1'b0;
      end
      check("arst quiet", 32'(quiet_ok), 32'd1);
      run_op("123xm45",   16'd123,    -16'sd45,  32'hFFFF_EA61, 1'b0, 16'hEA61, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
